// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: shadow EX/MEM/WB destination tags, forwarding select
// priority, load-use stall insertion, register-file write port and stall counter.
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 3,
    parameter int CNT_W        = 16,
    parameter int R0_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] RD4,
    output logic                  WB_signals,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  ld;
    } slot_t;

    localparam slot_t BUBBLE = '{v: 1'b0, rd: {REG_ADDR_W{1'b0}}, wr: 1'b0, ld: 1'b0};

    slot_t ex_r, mem_r, wb_r;
    logic [CNT_W-1:0] stall_count_r;

    logic       ex_a_s, mem_a_s, wb_a_s;
    logic       ex_b_s, mem_b_s, wb_b_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       stall_s;

    function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] rs,
                                        input logic use_src, input logic valid);
        logic r0_s;
        r0_s = (R0_HARDWIRED != 0) && (rs == {REG_ADDR_W{1'b0}});
        return use_src & valid & s.v & s.wr & (s.rd == rs) & ~r0_s;
    endfunction

    // A load sitting in EX cannot forward yet, so it falls through to older stages.
    function automatic logic [1:0] fwd_select(input logic m_ex, input logic ex_ld,
                                              input logic m_mem, input logic m_wb);
        logic [1:0] sel;
        if (m_ex && !ex_ld) begin
            sel = 2'd1;
        end else if (m_mem) begin
            sel = 2'd2;
        end else if (m_wb) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Source/tag comparison, forwarding priority and load-use detection.
    always_comb begin
        ex_a_s  = slot_match(ex_r,  id_rs1, id_use_rs1, id_valid);
        mem_a_s = slot_match(mem_r, id_rs1, id_use_rs1, id_valid);
        wb_a_s  = slot_match(wb_r,  id_rs1, id_use_rs1, id_valid);
        ex_b_s  = slot_match(ex_r,  id_rs2, id_use_rs2, id_valid);
        mem_b_s = slot_match(mem_r, id_rs2, id_use_rs2, id_valid);
        wb_b_s  = slot_match(wb_r,  id_rs2, id_use_rs2, id_valid);
        fwd_a_s = fwd_select(ex_a_s, ex_r.ld, mem_a_s, wb_a_s);
        fwd_b_s = fwd_select(ex_b_s, ex_r.ld, mem_b_s, wb_b_s);
        stall_s = ~flush & (ex_a_s | ex_b_s) & ex_r.ld;
    end

    // Shadow tag pipeline; stall or flush injects a bubble into EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_r  <= BUBBLE;
            mem_r <= BUBBLE;
            wb_r  <= BUBBLE;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (!stall_s && !flush) begin
                ex_r <= '{v: id_valid, rd: id_rd, wr: id_reg_write, ld: id_mem_read};
            end else begin
                ex_r <= BUBBLE;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ForwardA    = fwd_a_s;
    assign ForwardB    = fwd_b_s;
    assign stall       = stall_s;
    assign ex_rd       = ex_r.rd;
    assign mem_rd      = mem_r.rd;
    assign RD4         = wb_r.rd;
    assign WB_signals  = wb_r.v & wb_r.wr;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed cycle table, hand sequences for async
// reset and counter saturation, then random stimulus against a reference model.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [2:0] id_rs1 = 3'd0, id_rs2 = 3'd0, id_rd = 3'd0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

    logic [1:0]  fa, fb, fa_s, fb_s;
    logic        st, st_s, we, we_s;
    logic [2:0]  exr, memr, rd4, exr_s, memr_s, rd4_s;
    logic [15:0] cnt;
    logic [5:0]  cnt_s;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ForwardA(fa), .ForwardB(fb), .stall(st), .ex_rd(exr), .mem_rd(memr),
        .RD4(rd4), .WB_signals(we), .stall_count(cnt)
    );

    hazard_forward_unit #(.CNT_W(6)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ForwardA(fa_s), .ForwardB(fb_s), .stall(st_s), .ex_rd(exr_s), .mem_rd(memr_s),
        .RD4(rd4_s), .WB_signals(we_s), .stall_count(cnt_s)
    );

    typedef struct {
        bit v; bit [2:0] rs1; bit [2:0] rs2; bit u1; bit u2;
        bit [2:0] rd; bit rw; bit ld; bit fl;
        int efa; int efb; int est; int ewe;
    } vec_t;

    typedef struct { bit v; bit [2:0] rd; bit wr; bit ld; } mslot_t;

    mslot_t pipe[3];   // [0]=EX, [1]=MEM, [2]=WB : instructions in flight, youngest first
    int stall_total;
    int errors = 0;
    int checks = 0;
    vec_t tbl[18];

    function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw,
                                bit ld, bit fl, int efa, int efb, int est, int ewe);
        vec_t t;
        t.v = v; t.rs1 = 3'(rs1); t.rs2 = 3'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = 3'(rd); t.rw = rw; t.ld = ld; t.fl = fl;
        t.efa = efa; t.efb = efb; t.est = est; t.ewe = ewe;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit produces(int k, bit [2:0] rs, bit u);
        return u && id_valid && pipe[k].v && pipe[k].wr && pipe[k].rd == rs && rs != 3'd0;
    endfunction

    // Youngest usable producer wins; a load still in EX has no data yet.
    function automatic int model_fwd(bit [2:0] rs, bit u);
        int sel = 0;
        for (int k = 2; k >= 0; k--) begin
            if (produces(k, rs, u) && !(k == 0 && pipe[0].ld)) sel = k + 1;
        end
        return sel;
    endfunction

    function automatic int model_stall();
        return (!flush && pipe[0].ld && (produces(0, id_rs1, id_use_rs1) ||
                produces(0, id_rs2, id_use_rs2))) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 3'd0, wr: 1'b0, ld: 1'b0};
        stall_total = 0;
    endtask

    task automatic check_state();
        chk("ex_rd", int'(exr), int'(pipe[0].rd));
        chk("mem_rd", int'(memr), int'(pipe[1].rd));
        chk("RD4", int'(rd4), int'(pipe[2].rd));
        chk("WB_signals", int'(we), (pipe[2].v && pipe[2].wr) ? 1 : 0);
        chk("stall_count", int'(cnt), stall_total > 65535 ? 65535 : stall_total);
        chk("stall_count_sat6", int'(cnt_s), stall_total > 63 ? 63 : stall_total);
    endtask

    // Apply one decode cycle, compare, then advance the model across the clock edge.
    task automatic step(input vec_t t, input bit use_tbl);
        int s;
        id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
        id_rd = t.rd; id_reg_write = t.rw; id_mem_read = t.ld; flush = t.fl;
        #2;
        s = model_stall();
        if (use_tbl) begin
            chk("tbl_ForwardA", int'(fa), t.efa);
            chk("tbl_ForwardB", int'(fb), t.efb);
            chk("tbl_stall", int'(st), t.est);
            chk("tbl_WB_signals", int'(we), t.ewe);
        end else begin
            chk("ForwardA", int'(fa), model_fwd(id_rs1, id_use_rs1));
            chk("ForwardB", int'(fb), model_fwd(id_rs2, id_use_rs2));
            chk("stall", int'(st), s);
        end
        check_state();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (s == 0 && !t.fl) pipe[0] = '{v: t.v, rd: t.rd, wr: t.rw, ld: t.ld};
        else pipe[0] = '{v: 1'b0, rd: 3'd0, wr: 1'b0, ld: 1'b0};
        stall_total += s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle, t;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            v rs1 rs2 u1 u2 rd rw ld fl  fa fb st we
        tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 3, 4, 1, 1, 6, 0, 0, 0, 2, 1, 0, 0);
        tbl[3]  = mk(1, 3, 6, 1, 1, 2, 1, 1, 0, 3, 0, 0, 1);
        tbl[4]  = mk(1, 4, 2, 1, 1, 5, 1, 0, 0, 3, 0, 1, 1);
        tbl[5]  = mk(1, 4, 2, 1, 1, 5, 1, 0, 0, 0, 2, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 3, 3, 1, 1, 4, 1, 1, 0, 1, 1, 0, 1);
        tbl[9]  = mk(1, 4, 0, 1, 0, 7, 1, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[17] = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        model_reset();
        #12 reset = 1'b0;
        @(posedge clk);
        #1;
        #2;
        chk("reset_ForwardA", int'(fa), 0);
        chk("reset_ForwardB", int'(fb), 0);
        chk("reset_stall", int'(st), 0);
        check_state();
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) step(tbl[i], 1'b1);
        chk("tbl_total_stalls", int'(cnt), 1);

        // Producer of R5 reaches WB, then reset lands between clock edges.
        t = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        step(t, 1'b0);
        step(idle, 1'b0);
        step(idle, 1'b0);
        chk("pre_reset_WB_signals", int'(we), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_WB_signals", int'(we), 0);
        chk("async_RD4", int'(rd4), 0);
        chk("async_stall_count", int'(cnt), 0);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(idle, 1'b0);

        // Back-to-back self-dependent loads: stalls every other cycle, driving saturation.
        t = mk(1, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 140; i++) step(t, 1'b0);
        chk("sat6_hold", int'(cnt_s), 63);
        step(idle, 1'b0);

        for (int i = 0; i < 400; i++) begin
            t.v  = ($urandom_range(0, 9) != 0);
            t.rs1 = 3'($urandom_range(0, 3));
            t.rs2 = 3'($urandom_range(0, 3));
            t.u1 = 1'($urandom_range(0, 1));
            t.u2 = 1'($urandom_range(0, 1));
            t.rd = 3'($urandom_range(0, 3));
            t.rw = ($urandom_range(0, 3) != 0);
            t.ld = ($urandom_range(0, 2) == 0);
            t.fl = ($urandom_range(0, 7) == 0);
            step(t, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
